risc_controller: RTL and testbench
==================================

// Module: risc_controller
// PURPOSE
// - Moore FSM plus instruction register that sequences the 8-entry regfile/shifter/ALU datapath.
// - Latches one 16-bit instruction on start and steps the datapath through operand fetch, ALU and write-back.
// - Raises w when idle, so a top level or testbench can issue instructions back-to-back.
// PARAMETERS
// DATA_W    16  datapath / sximm8 width
// REG_BITS  3   register index width (8 registers)
// PORTS
// clk       in   1         rising-edge clock
// reset     in   1         asynchronous, active-high; forces WAIT
// s         in   1         start; sampled only in WAIT
// instr     in   16        instruction; latched into IR when s is accepted
// readnum   out  REG_BITS  regfile read index
// writenum  out  REG_BITS  regfile write index
// write     out  1         regfile write enable
// vsel      out  1         write-back source: 0 = datapath C, 1 = sximm8
// sximm8    out  DATA_W    IR[7:0] sign-extended
// shift     out  2         IR[4:3] to shifter
// aluop     out  2         ALU op
// asel      out  1         1 = force ALU A input to 0
// loada     out  1         A register load enable
// loadb     out  1         B register load enable
// loadc     out  1         C register load enable
// loads     out  1         status register load enable
// w         out  1         1 = idle in WAIT
// err       out  1         one-cycle pulse on an illegal instruction
// BEHAVIOUR
// - Instruction fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
// - Legal instructions:
//   MOV Rn,#imm  = 110/10
//   MOV Rd,Rm    = 110/00
//   ADD          = 101/00
//   CMP          = 101/01
//   AND          = 101/10
//   MVN          = 101/11
// - Reset: async; state=WAIT, IR=0. While reset is high: all loads/write/err=0, w=1, readnum=writenum=0.
// - Outputs are decoded combinationally from state and IR (Moore). Unlisted outputs are 0 in every state.
// - FSM states and transitions:
//   WAIT:      w=1. If s: IR<=instr, go to DECODE. Otherwise hold.
//   DECODE:    MOV imm -> WIMM; MOV reg -> GETB; 101/xx -> GETA; any other -> WAIT with err=1 this cycle.
//   GETA:      readnum=Rn, loada=1 -> GETB.
//   GETB:      readnum=Rm, loadb=1 -> ALU.
//   ALU:       aluop=op, shift=sh. MOV reg: aluop=00, asel=1.
//              CMP: loads=1, loadc=0 -> WAIT.
//              Otherwise loadc=1, loads=(opcode==101) -> WREG.
//   WREG:      writenum=Rd, vsel=0, write=1 -> WAIT.
//   WIMM:      writenum=Rn, vsel=1, write=1 -> WAIT.
// - Latency, counted from the edge that samples s until w=1 again:
//   MOV imm = 3 cycles, MOV reg = 5, ADD/AND/MVN = 6, CMP = 5.
// - s while not in WAIT is ignored. instr changes while not in WAIT have no effect (IR holds).
// - s held high: the next instruction is accepted on the first WAIT cycle (back-to-back, with one WAIT cycle between).
// - Reset asserted mid-instruction: write/loads drop immediately, the instruction is abandoned, and no partial write-back occurs.
// - Rd==Rn or Rd==Rm is legal; no hazard logic is needed, because every read completes before WREG.
// - sximm8 = {{DATA_W-8{IR[7]}},IR[7:0]}; it is valid in every state.
// STRUCTURE
// - Package risc_pkg: opcode/op localparams, state_t enum {WAIT,DECODE,GETA,GETB,ALU,WREG,WIMM}, field-slice constants.
// - Sub-module instr_dec (combinational): IR -> Rn/Rd/Rm/sh/op/opcode/sximm8/legal.
// - This module holds only the IR, the state register and the output decode.
// TESTING
// - Reset: assert reset mid-GETB -> state WAIT, w=1, loadb=0 in the same cycle without waiting for a clock edge.
// - MOV R3,#-5: s=1, instr=16'hD3FB -> WIMM: writenum=3, vsel=1, write=1, sximm8=16'hFFFB; w=1 three cycles after s is sampled.
// - ADD R2,R1,R0 (16'hA140): sequence GETA(readnum=1,loada) -> GETB(readnum=0,loadb) -> ALU(aluop=00,loadc,loads) -> WREG(writenum=2,write).
// - CMP R1,R0 (16'hA900): loads=1 in ALU, loadc=0, no write cycle, back to WAIT after ALU.
// - Illegal 16'hE000 -> err pulses 1 cycle in DECODE, no load/write asserted, WAIT next cycle.
// - s held high with instr changing during execution -> the latched IR is used; the second instruction starts on the first WAIT cycle.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC controller: sizes, encodings and FSM states.
// Field positions describe the fixed 16-bit instruction layout.
package risc_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_BITS = 3;
  localparam int INSTR_W  = 16;
  localparam int IMM_W    = 8;

  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    GETA,
    GETB,
    ALU,
    WREG,
    WIMM
  } state_t;

endpackage

// File: rtl/risc_controller_dec.sv
// Combinational instruction field extraction and legality check.
// sximm8 is produced here so it is valid in every controller state.
module instr_dec
  import risc_pkg::*;
#(
  parameter int DATA_W   = risc_pkg::DATA_W,
  parameter int REG_BITS = risc_pkg::REG_BITS
) (
  input  logic [INSTR_W-1:0]  ir,
  output logic [2:0]          opcode,
  output logic [1:0]          op,
  output logic [REG_BITS-1:0] rn,
  output logic [REG_BITS-1:0] rd,
  output logic [REG_BITS-1:0] rm,
  output logic [1:0]          sh,
  output logic [DATA_W-1:0]   sximm8,
  output logic                legal
);

  logic is_mov;
  logic is_alu;

  assign opcode = ir[OPC_LSB +: 3];
  assign op     = ir[OP_LSB +: 2];
  assign rn     = ir[RN_LSB +: REG_BITS];
  assign rd     = ir[RD_LSB +: REG_BITS];
  assign rm     = ir[RM_LSB +: REG_BITS];
  assign sh     = ir[SH_LSB +: 2];
  assign sximm8 = {{(DATA_W-IMM_W){ir[IMM_W-1]}},
                   ir[IMM_W-1:0]};

  assign is_mov = (opcode == OPC_MOV) &&
                  ((op == OP_MOV_IMM) ||
                   (op == OP_MOV_REG));
  assign is_alu = (opcode == OPC_ALU);
  assign legal  = is_mov || is_alu;

endmodule

// File: rtl/risc_controller.sv
// Moore controller: instruction register, state register and output decode
// that walks the regfile/shifter/ALU datapath through one instruction.
module risc_controller
  import risc_pkg::*;
#(
  parameter int DATA_W   = risc_pkg::DATA_W,
  parameter int REG_BITS = risc_pkg::REG_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s,
  input  logic [INSTR_W-1:0]  instr,
  output logic [REG_BITS-1:0] readnum,
  output logic [REG_BITS-1:0] writenum,
  output logic                write,
  output logic                vsel,
  output logic [DATA_W-1:0]   sximm8,
  output logic [1:0]          shift,
  output logic [1:0]          aluop,
  output logic                asel,
  output logic                loada,
  output logic                loadb,
  output logic                loadc,
  output logic                loads,
  output logic                w,
  output logic                err
);

  state_t             state;
  state_t             next;
  logic [INSTR_W-1:0] ir;

  logic [2:0]          opcode;
  logic [1:0]          op;
  logic [REG_BITS-1:0] rn;
  logic [REG_BITS-1:0] rd;
  logic [REG_BITS-1:0] rm;
  logic [1:0]          sh;
  logic                legal;

  logic mov_imm;
  logic mov_reg;
  logic is_alu;
  logic is_cmp;

  instr_dec #(
    .DATA_W   (DATA_W),
    .REG_BITS (REG_BITS)
  ) u_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sximm8 (sximm8),
    .legal  (legal)
  );

  assign mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
  assign mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  assign is_alu  = (opcode == OPC_ALU);
  assign is_cmp  = is_alu && (op == OP_CMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == WAIT && s)
        ir <= instr;
    end
  end

  always_comb begin
    next     = state;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = 1'b0;
    shift    = 2'b00;
    aluop    = 2'b00;
    asel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    w        = 1'b0;
    err      = 1'b0;
    unique case (state)
      WAIT: begin
        w = 1'b1;
        if (s)
          next = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          !legal: begin
            err  = 1'b1;
            next = WAIT;
          end
          mov_imm: next = WIMM;
          mov_reg: next = GETB;
          default: next = GETA;
        endcase
      end
      GETA: begin
        readnum = rn;
        loada   = 1'b1;
        next    = GETB;
      end
      GETB: begin
        readnum = rm;
        loadb   = 1'b1;
        next    = ALU;
      end
      ALU: begin
        shift = sh;
        aluop = mov_reg ? 2'b00 : op;
        asel  = mov_reg;
        // CMP only updates status; nothing is written back
        if (is_cmp) begin
          loads = 1'b1;
          next  = WAIT;
        end else begin
          loadc = 1'b1;
          loads = is_alu;
          next  = WREG;
        end
      end
      WREG: begin
        writenum = rd;
        write    = 1'b1;
        next     = WAIT;
      end
      WIMM: begin
        writenum = rn;
        vsel     = 1'b1;
        write    = 1'b1;
        next     = WAIT;
      end
      default: next = WAIT;
    endcase
  end

endmodule

// File: tb/tb_risc_controller.sv
// Bench for risc_controller: instruction-level model of the expected
// per-cycle control outputs plus directed literal checks.
module tb_risc_controller;

  typedef struct packed {
    logic [2:0] rn;
    logic [2:0] wn;
    logic       write;
    logic       vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
    logic       asel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       w;
    logic       err;
  } ov_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s = 1'b0;
  logic [15:0] instr = '0;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic [15:0] sximm8;
  logic [1:0]  shift;
  logic [1:0]  aluop;
  logic        asel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        w;
  logic        err;

  int checks = 0;
  int failures = 0;

  ov_t         q[$];
  logic [15:0] m_ir = '0;

  risc_controller dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .instr    (instr),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .sximm8   (sximm8),
    .shift    (shift),
    .aluop    (aluop),
    .asel     (asel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .w        (w),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Expected list of non-idle cycles an instruction produces.
  function automatic void enqueue(input logic [15:0] i);
    logic [2:0] opc;
    logic [1:0] op;
    bit         mimm;
    bit         mreg;
    bit         alu;
    bit         cmp;
    ov_t        o;
    opc  = i[15:13];
    op   = i[12:11];
    mimm = (opc == 3'b110) && (op == 2'b10);
    mreg = (opc == 3'b110) && (op == 2'b00);
    alu  = (opc == 3'b101);
    cmp  = alu && (op == 2'b01);
    o = '0;
    o.err = !(mimm || mreg || alu);
    q.push_back(o);
    if (mimm) begin
      o = '0;
      o.wn = i[10:8];
      o.vsel = 1'b1;
      o.write = 1'b1;
      q.push_back(o);
    end else if (mreg || alu) begin
      if (alu) begin
        o = '0;
        o.rn = i[10:8];
        o.loada = 1'b1;
        q.push_back(o);
      end
      o = '0;
      o.rn = i[2:0];
      o.loadb = 1'b1;
      q.push_back(o);
      o = '0;
      o.shift = i[4:3];
      o.aluop = alu ? op : 2'b00;
      o.asel = mreg;
      o.loads = alu;
      o.loadc = !cmp;
      q.push_back(o);
      if (!cmp) begin
        o = '0;
        o.wn = i[7:5];
        o.write = 1'b1;
        q.push_back(o);
      end
    end
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete();
      m_ir = '0;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (s) begin
      m_ir = instr;
      enqueue(instr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    ov_t e;
    ov_t g;
    e = '0;
    e.w = 1'b1;
    if (q.size() != 0)
      e = q[0];
    g = {readnum, writenum, write, vsel, shift, aluop,
         asel, loada, loadb, loadc, loads, w, err};
    chk("model_ctl", 32'(g), 32'(e));
    chk("model_sximm8", 32'(sximm8),
        32'({{8{m_ir[7]}}, m_ir[7:0]}));
  endtask

  task automatic step();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_lat(input logic [15:0] i, input int lat,
                         input string nm);
    int n;
    s = 1'b1;
    instr = i;
    step();
    s = 1'b0;
    instr = 16'($urandom);
    n = 1;
    while (!w && n < 20) begin
      step();
      n++;
    end
    chk(nm, 32'(n), 32'(lat));
  endtask

  initial begin
    int n;
    step();
    chk("rst_w", 32'(w), 32'd1);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_readnum", 32'(readnum), 32'd0);
    step();
    reset = 1'b0;
    step();

    s = 1'b1;
    instr = 16'hD3FB;
    step();
    s = 1'b0;
    instr = 16'hA140;
    chk("movi_decode_w", 32'(w), 32'd0);
    step();
    chk("movi_writenum", 32'(writenum), 32'd3);
    chk("movi_vsel", 32'(vsel), 32'd1);
    chk("movi_write", 32'(write), 32'd1);
    chk("movi_sximm8", 32'(sximm8), 32'hFFFB);
    step();
    chk("movi_lat3_w", 32'(w), 32'd1);

    s = 1'b1;
    instr = 16'hA140;
    step();
    s = 1'b0;
    instr = 16'hFFFF;
    step();
    chk("add_geta", 32'({readnum, loada}), 32'({3'd1, 1'b1}));
    step();
    chk("add_getb", 32'({readnum, loadb}), 32'({3'd0, 1'b1}));
    step();
    chk("add_alu", 32'({aluop, loadc, loads}), 32'({2'b00, 2'b11}));
    step();
    chk("add_wreg", 32'({writenum, write}), 32'({3'd2, 1'b1}));
    step();
    chk("add_lat6_w", 32'(w), 32'd1);

    run_lat(16'hA900, 5, "cmp_lat");
    run_lat(16'hB381, 6, "and_lat");
    run_lat(16'hBAD4, 6, "mvn_lat");
    run_lat(16'hC0AB, 5, "movr_lat");
    run_lat(16'hC800, 2, "ill_movop_lat");

    s = 1'b1;
    instr = 16'hE000;
    step();
    s = 1'b0;
    chk("ill_err", 32'({err, w, write, loada, loadb, loadc, loads}),
        32'(7'b1000000));
    step();
    chk("ill_done", 32'({err, w}), 32'(2'b01));

    s = 1'b1;
    instr = 16'hA140;
    step();
    instr = 16'hD3FB;
    n = 1;
    while (!w && n < 20) begin
      step();
      n++;
    end
    chk("b2b_first_lat", 32'(n), 32'd6);
    step();
    s = 1'b0;
    instr = 16'h0000;
    chk("b2b_second_start", 32'(w), 32'd0);
    n = 1;
    while (!w && n < 20) begin
      step();
      n++;
    end
    chk("b2b_second_lat", 32'(n), 32'd3);

    s = 1'b1;
    instr = 16'hA140;
    step();
    s = 1'b0;
    step();
    step();
    chk("getb_loadb", 32'(loadb), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_w", 32'(w), 32'd1);
    chk("rst_mid_loadb", 32'(loadb), 32'd0);
    chk("rst_mid_sximm8", 32'(sximm8), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    step();
    run_lat(16'hD3FB, 3, "post_rst_movi_lat");
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
